// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the architectural PC, issues one outstanding imem fetch at a time and
// hands fetched instructions to decode, handling redirects, halts and fetch errors.
module fetch_sequencer #(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned     MAX_WAIT     = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            halt_req,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] pc_out,
    output logic            halted,
    output logic            fetch_err
);

    localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] REQ     = 3'd1;
    localparam logic [2:0] WAIT    = 3'd2;
    localparam logic [2:0] DELIVER = 3'd3;
    localparam logic [2:0] HALT    = 3'd4;
    localparam logic [2:0] ERR     = 3'd5;

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            kill_q, kill_d;
    logic            halt_pend_q, halt_pend_d;
    logic [CntW-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic [XLEN-1:0] imem_addr_q;
    logic            imem_req_q, instr_valid_q, halted_q, fetch_err_q;

    logic redir_ok, redir_bad, timeout;

    always_comb begin
        redir_ok  = redirect_valid && (redirect_target[1:0] == 2'b00);
        redir_bad = redirect_valid && (redirect_target[1:0] != 2'b00);
        timeout   = (wait_cnt_q + CntW'(1)) == CntW'(MAX_WAIT);
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        kill_d      = kill_q;
        halt_pend_d = halt_pend_q | halt_req;
        wait_cnt_d  = wait_cnt_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        case (state_q)
            IDLE: begin
                if (redir_bad) begin
                    state_d = ERR;
                end else begin
                    if (redir_ok) pc_d = redirect_target;
                    state_d = REQ;
                end
            end
            REQ: begin
                wait_cnt_d = '0;
                if (redir_bad) begin
                    state_d = ERR;
                end else begin
                    // The request already went out with the old PC; drop its response.
                    if (redir_ok) begin
                        pc_d   = redirect_target;
                        kill_d = 1'b1;
                    end
                    state_d = WAIT;
                end
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q + CntW'(1);
                if (redir_bad) begin
                    state_d = ERR;
                end else if (redir_ok) begin
                    pc_d = redirect_target;
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        kill_d = 1'b1;
                        if (timeout) state_d = ERR;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + XLEN'(4);
                        state_d    = DELIVER;
                    end
                end else if (timeout) begin
                    state_d = ERR;
                end
            end
            DELIVER: begin
                if (redir_bad) begin
                    state_d = ERR;
                end else if (redir_ok) begin
                    pc_d    = redirect_target;
                    state_d = REQ;
                end else if (!stall) begin
                    state_d = REQ;
                end
            end
            HALT:    state_d = HALT;
            ERR:     state_d = ERR;
            default: state_d = ERR;
        endcase
        // Every path into REQ is a halt point.
        if (state_d == REQ && halt_pend_d) state_d = HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= RESET_VECTOR;
            kill_q        <= 1'b0;
            halt_pend_q   <= 1'b0;
            wait_cnt_q    <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            imem_addr_q   <= '0;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            halted_q      <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            kill_q        <= kill_d;
            halt_pend_q   <= halt_pend_d;
            wait_cnt_q    <= wait_cnt_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            imem_req_q    <= (state_d == REQ);
            instr_valid_q <= (state_d == DELIVER);
            halted_q      <= (state_d == HALT);
            fetch_err_q   <= (state_d == ERR);
            if (state_d == REQ) imem_addr_q <= pc_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = imem_addr_q;
    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign pc_out      = pc_q;
    assign halted      = halted_q;
    assign fetch_err   = fetch_err_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Controls the program counter and the instruction-memory fetch handshake for the core. Holds the architectural PC, issues one outstanding fetch at a time, and delivers fetched instructions to decode under a valid/stall handshake. Applies branch/jump redirects, flushes in-flight fetches, and handles halt requests. Flags fetch errors (memory timeout, misaligned redirect target) with a sticky error output.

Parameters:
XLEN, 32, width of PC and address bus
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset
MAX_WAIT, 15, cycles spent in WAIT without imem_rvalid before timeout error

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
stall  input  1  decode cannot accept the presented instruction
redirect_valid  input  1  taken branch/jump this cycle
redirect_target  input  XLEN  new PC when redirect_valid=1
halt_req  input  1  request to stop fetching
imem_req  output  1  fetch request; single-cycle pulse
imem_addr  output  XLEN  fetch address; equals pc_out while imem_req=1
imem_rvalid  input  1  fetch response valid
imem_rdata  input  32  fetched instruction word
instr_valid  output  1  instr/instr_pc are valid for decode
instr  output  32  delivered instruction
instr_pc  output  XLEN  PC of the delivered instruction
pc_out  output  XLEN  current fetch PC
halted  output  1  fetch stopped by halt
fetch_err  output  1  sticky error flag

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, pc_out=RESET_VECTOR, imem_req=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0, halted=0, fetch_err=0, kill=0, halt_pend=0, wait_cnt=0. Reset overrides every other input. A mid-operation reset drops the in-flight fetch, and a late imem_rvalid after reset is ignored.
- All outputs are registered (Moore). States: IDLE, REQ, WAIT, DELIVER, HALT, ERR.
- IDLE: transitions to REQ on the next cycle, or to HALT if halt_pend is set.
- REQ: imem_req=1 and imem_addr=pc_out for exactly 1 cycle. Clears wait_cnt, then transitions to WAIT.
- WAIT: wait_cnt increments each cycle.
  - On imem_rvalid with kill=0: capture instr=imem_rdata and instr_pc=pc_out; set pc_out=pc_out+4 (mod 2^XLEN, wraps from 0xFFFF_FFFC to 0); transition to DELIVER.
  - On imem_rvalid with kill=1: discard the data, clear kill, transition to REQ.
  - If wait_cnt reaches MAX_WAIT with no imem_rvalid: transition to ERR.
- DELIVER: instr_valid=1, and instr/instr_pc are held stable while stall=1. When stall=0, the instruction is consumed that cycle; instr_valid falls on the next cycle and the block transitions to REQ, or to HALT if halt_pend is set.
- Minimum latency: REQ at cycle N, imem_rvalid at N+1, instr_valid=1 at N+2, next REQ at N+3. Throughput is at most one instruction per 3 cycles.
- Redirect (redirect_valid=1) in IDLE, REQ, WAIT or DELIVER:
  - pc_out=redirect_target on the next edge.
  - In REQ or WAIT: set kill so the pending response is discarded. If imem_rvalid arrives in the same WAIT cycle, the data is discarded, the redirect wins, and the next state is REQ.
  - In DELIVER: instr_valid drops next cycle; the next state is REQ. If stall=0 in that cycle, the instruction counts as consumed.
- Misaligned redirect (redirect_target[1:0]!=0): no PC update; transition to ERR.
- ERR: fetch_err=1, imem_req=0, instr_valid=0. Exits only on rst.
- halt_req: latched into halt_pend in any state and acted on only at REQ entry points, so an in-flight fetch completes and is delivered first. HALT: halted=1, imem_req=0, pc_out frozen; redirects are ignored. Exits only on rst.
- Redirect and halt_req in the same cycle: pc_out takes the target, then the block enters HALT at the next REQ entry point.
- imem_rvalid outside WAIT is ignored.

Test Plan:
- Reset then imem_rvalid 1 cycle after each req with rdata=0x1000+addr, stall=0 → imem_addr sequence 0x0, 0x4, 0x8, 0xC; instr_pc matches each; pc_out=0x10 after the 4th delivery; instr_valid high 1 cycle per instruction.
- Hold stall=1 for 5 cycles during DELIVER → instr/instr_pc/instr_valid stable all 5 cycles; no imem_req until the cycle after stall falls.
- redirect_valid with target 0x200 while in WAIT; response arrives 2 cycles later → response discarded, instr_valid stays 0, next imem_addr=0x200, delivered instr_pc=0x200.
- Same-cycle redirect (target 0x80) and imem_rvalid in WAIT → no delivery; next imem_addr=0x80. Separately, redirect with target 0x102 → fetch_err=1 and no further imem_req until rst.
- Withhold imem_rvalid for 15 cycles → fetch_err=1, state ERR. Then assert rst 1 cycle → fetch_err=0, pc_out=RESET_VECTOR, and fetching resumes at 0x0.
- halt_req pulsed during WAIT → that instruction is still delivered, then halted=1 and pc_out frozen at last+4. A subsequent redirect to 0x40 has no effect.
